// File: rtl/odesa_pattern_gen.sv
// odesa_pattern_gen
// Spatiotemporal spike-pattern generator for ODESA self-test and training.
// Each trial is two sweeps of one-hot pulses across all channels, followed by
// a supervisory label pulse. The sweep order, timing and trial count are
// latched when a run starts.
//
// Optional build macro: ODESA_PG_JITTER_EN
//   defined     : a 16-bit LFSR stretches every LOW interval by 0..3 cycles
//   not defined : timing is fully deterministic
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_start, i_abort    run start (IDLE only) / synchronous abort
//   i_mode              sweep order: 0 asc/asc, 1 desc/desc, 2 asc/desc, 3 desc/asc
//   i_spl, i_dlt        pulse width (0 acts as 1) / low cycles between pulses
//   i_gap, i_wait       gap between sweeps / idle cycles after the label
//   i_label, i_reps     label value / number of trials
//   o_event, o_label    one-hot event pulse / label pulse
//   o_busy, o_done      run in progress / one-cycle completion pulse
//   o_rep_cnt           completed trials in the current run
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for i_start
// PULSE   | one channel high for spl cycles
// LOW     | dlt (+ jitter) low cycles between pulses
// SWGAP   | gap low cycles between sweep 1 and sweep 2
// LABEL   | label held for spl cycles after the final pulse
// WAIT    | wait idle cycles before the next trial
// DONE    | one-cycle completion pulse
module odesa_pattern_gen #(
  parameter int p_channels = 8,
  parameter int p_label_w  = 4,
  parameter int p_cnt_w    = 16,
  parameter int p_rep_w    = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [1:0]            i_mode,
  input  logic [p_cnt_w-1:0]    i_spl,
  input  logic [p_cnt_w-1:0]    i_dlt,
  input  logic [p_cnt_w-1:0]    i_gap,
  input  logic [p_cnt_w-1:0]    i_wait,
  input  logic [p_label_w-1:0]  i_label,
  input  logic [p_rep_w-1:0]    i_reps,
  output logic [p_channels-1:0] o_event,
  output logic [p_label_w-1:0]  o_label,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [p_rep_w-1:0]    o_rep_cnt
);

  localparam int IW = (p_channels > 1) ? $clog2(p_channels) : 1;
  // one extra bit so dlt plus jitter can never wrap
  localparam int CW = p_cnt_w + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(p_channels - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PULSE, S_LOW, S_SWGAP, S_LABEL, S_WAIT, S_DONE
  } state_t;

  state_t                r_state;
  logic [IW-1:0]         r_idx;
  logic                  r_sweep;
  logic [CW-1:0]         r_cnt;
  logic [p_rep_w-1:0]    r_rep_cnt;
  logic [1:0]            r_mode;
  logic [p_cnt_w-1:0]    r_spl;
  logic [p_cnt_w-1:0]    r_dlt;
  logic [p_cnt_w-1:0]    r_gap;
  logic [p_cnt_w-1:0]    r_wait;
  logic [p_label_w-1:0]  r_lbl;
  logic [p_rep_w-1:0]    r_reps;
  logic [p_channels-1:0] r_event;
  logic [p_label_w-1:0]  r_label;
  logic                  r_busy;
  logic                  r_done;

  state_t                w_state_nxt;
  logic [IW-1:0]         w_idx_nxt;
  logic                  w_sweep_nxt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [p_rep_w-1:0]    w_rep_nxt;
  logic                  w_trial_end;
  logic                  w_label_nxt;
  logic [p_channels-1:0] w_event_nxt;
  logic [p_cnt_w-1:0]    w_spl_in;
  logic [1:0]            w_jit;
  logic [CW-1:0]         w_low_len;
  logic                  w_desc;
  logic                  w_desc2;
  logic                  w_last;
  logic [IW-1:0]         w_start1;
  logic [IW-1:0]         w_start2;
  logic [IW-1:0]         w_end2;
  logic                  w_go;

`ifdef ODESA_PG_JITTER_EN
  logic [15:0] r_lfsr;

  // Fibonacci LFSR, taps 16,14,13,11; free-running from reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_lfsr <= 16'hACE1;
    else          r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  assign w_jit = r_lfsr[1:0];
`else
  assign w_jit = 2'd0;
`endif

  assign w_go      = i_start && !i_abort;
  assign w_spl_in  = (i_spl == '0) ? p_cnt_w'(1) : i_spl;
  assign w_low_len = CW'(r_dlt) + CW'(w_jit);
  assign w_desc2   = r_mode[0] ^ r_mode[1];
  assign w_desc    = r_sweep ? w_desc2 : r_mode[0];
  assign w_last    = w_desc ? (r_idx == '0) : (r_idx == LAST_IDX);
  assign w_start1  = r_mode[0] ? LAST_IDX : '0;
  assign w_start2  = w_desc2 ? LAST_IDX : '0;
  assign w_end2    = w_desc2 ? '0 : LAST_IDX;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_sweep_nxt = r_sweep;
    w_cnt_nxt   = r_cnt;
    w_rep_nxt   = r_rep_cnt;
    w_trial_end = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_rep_nxt = '0;
          if (i_reps == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_PULSE;
            w_sweep_nxt = 1'b0;
            w_idx_nxt   = i_mode[0] ? LAST_IDX : '0;
            w_cnt_nxt   = CW'(w_spl_in) - CW'(1);
          end
        end
      end
      S_PULSE: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else if (!w_last) begin
          w_idx_nxt = w_desc ? (r_idx - IW'(1)) : (r_idx + IW'(1));
          if (w_low_len == '0) begin
            w_cnt_nxt = CW'(r_spl) - CW'(1);
          end else begin
            w_state_nxt = S_LOW;
            w_cnt_nxt   = w_low_len - CW'(1);
          end
        end else if (!r_sweep) begin
          w_sweep_nxt = 1'b1;
          w_idx_nxt   = w_start2;
          if (r_gap == '0) begin
            w_cnt_nxt = CW'(r_spl) - CW'(1);
          end else begin
            w_state_nxt = S_SWGAP;
            w_cnt_nxt   = CW'(r_gap) - CW'(1);
          end
        end else begin
          w_state_nxt = S_LABEL;
          w_cnt_nxt   = CW'(r_spl) - CW'(1);
        end
      end
      S_LOW, S_SWGAP: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else begin
          w_state_nxt = S_PULSE;
          w_cnt_nxt   = CW'(r_spl) - CW'(1);
        end
      end
      S_LABEL: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else if (r_wait == '0) begin
          w_trial_end = 1'b1;
        end else begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = CW'(r_wait) - CW'(1);
        end
      end
      S_WAIT: begin
        if (r_cnt != '0) w_cnt_nxt = r_cnt - CW'(1);
        else             w_trial_end = 1'b1;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_trial_end) begin
      w_rep_nxt = r_rep_cnt + p_rep_w'(1);
      if (w_rep_nxt == r_reps) begin
        w_state_nxt = S_DONE;
      end else begin
        w_state_nxt = S_PULSE;
        w_sweep_nxt = 1'b0;
        w_idx_nxt   = w_start1;
        w_cnt_nxt   = CW'(r_spl) - CW'(1);
      end
    end

    // abort drops everything except the completed-trial count
    if (i_abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_rep_nxt   = r_rep_cnt;
    end
  end

  // label spans the final sweep-2 pulse plus the LABEL state
  assign w_label_nxt = (w_state_nxt == S_LABEL) ||
                       ((w_state_nxt == S_PULSE) && w_sweep_nxt && (w_idx_nxt == w_end2));

  always_comb begin
    w_event_nxt = '0;
    for (int i = 0; i < p_channels; i++) w_event_nxt[i] = (w_idx_nxt == IW'(i));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_sweep   <= 1'b0;
      r_cnt     <= '0;
      r_rep_cnt <= '0;
      r_mode    <= '0;
      r_spl     <= '0;
      r_dlt     <= '0;
      r_gap     <= '0;
      r_wait    <= '0;
      r_lbl     <= '0;
      r_reps    <= '0;
      r_event   <= '0;
      r_label   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && w_go) begin
        r_mode <= i_mode;
        r_spl  <= w_spl_in;
        r_dlt  <= i_dlt;
        r_gap  <= i_gap;
        r_wait <= i_wait;
        r_lbl  <= i_label;
        r_reps <= i_reps;
      end
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_sweep   <= w_sweep_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rep_cnt <= w_rep_nxt;
      r_event   <= (w_state_nxt == S_PULSE) ? w_event_nxt : '0;
      r_label   <= w_label_nxt ? r_lbl : '0;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= (w_state_nxt == S_DONE);
    end
  end

  assign o_event   = r_event;
  assign o_label   = r_label;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_rep_cnt = r_rep_cnt;

endmodule

// File: tb/tb_odesa_pattern_gen.sv
module tb_odesa_pattern_gen;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic        i_abort;
  logic [1:0]  i_mode;
  logic [15:0] i_spl;
  logic [15:0] i_dlt;
  logic [15:0] i_gap;
  logic [15:0] i_wait;
  logic [3:0]  i_label;
  logic [9:0]  i_reps;
  logic [7:0]  o_event;
  logic [3:0]  o_label;
  logic        o_busy;
  logic        o_done;
  logic [9:0]  o_rep_cnt;

  always #5 clk = ~clk;

  odesa_pattern_gen dut (
    .i_clk     (clk),
    .i_rst_n   (i_rst_n),
    .i_start   (i_start),
    .i_abort   (i_abort),
    .i_mode    (i_mode),
    .i_spl     (i_spl),
    .i_dlt     (i_dlt),
    .i_gap     (i_gap),
    .i_wait    (i_wait),
    .i_label   (i_label),
    .i_reps    (i_reps),
    .o_event   (o_event),
    .o_label   (o_label),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_rep_cnt (o_rep_cnt)
  );

  typedef struct packed {
    logic [7:0] ev;
    logic [3:0] lb;
    logic       busy;
    logic       done;
    logic [9:0] rep;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   done_c;

  task automatic push(input logic [7:0] ev, input logic [3:0] lb,
                      input logic busy, input logic done, input logic [9:0] rep);
    exp_t e;
    e.ev = ev; e.lb = lb; e.busy = busy; e.done = done; e.rep = rep;
    sb.push_back(e);
  endtask

  // Expected per-cycle trace of a full run, built from the trial schedule.
  task automatic model_run(input int mode, input int spl, input int dlt, input int gap,
                           input int wt, input logic [3:0] lbl, input int reps);
    int  s_eff;
    bit  desc;
    int  ch;
    bit  fin;
    s_eff = (spl == 0) ? 1 : spl;
    for (int t = 0; t < reps; t++) begin
      for (int s = 0; s < 2; s++) begin
        if (s == 0) desc = (mode == 1) || (mode == 3);
        else        desc = (mode == 1) || (mode == 2);
        for (int k = 0; k < 8; k++) begin
          ch  = desc ? 7 - k : k;
          fin = (s == 1) && (k == 7);
          for (int c = 0; c < s_eff; c++) push(8'(1) << ch, fin ? lbl : 4'h0, 1'b1, 1'b0, 10'(t));
          if (k < 7) begin
            for (int c = 0; c < dlt; c++) push(8'h00, 4'h0, 1'b1, 1'b0, 10'(t));
          end else if (s == 0) begin
            for (int c = 0; c < gap; c++) push(8'h00, 4'h0, 1'b1, 1'b0, 10'(t));
          end
        end
      end
      for (int c = 0; c < s_eff; c++) push(8'h00, lbl, 1'b1, 1'b0, 10'(t));
      for (int c = 0; c < wt; c++) push(8'h00, 4'h0, 1'b1, 1'b0, 10'(t));
    end
    push(8'h00, 4'h0, 1'b1, 1'b1, 10'(reps));
    push(8'h00, 4'h0, 1'b0, 1'b0, 10'(reps));
  endtask

  // Called in the second half of a cycle; start is sampled on the next edge.
  task automatic start_run(input int mode, input int spl, input int dlt, input int gap,
                           input int wt, input logic [3:0] lbl, input int reps);
    i_mode  = 2'(mode);
    i_spl   = 16'(spl);
    i_dlt   = 16'(dlt);
    i_gap   = 16'(gap);
    i_wait  = 16'(wt);
    i_label = lbl;
    i_reps  = 10'(reps);
    i_start = 1'b1;
    model_run(mode, spl, dlt, gap, wt, lbl, reps);
    @(posedge clk);
    #1 i_start = 1'b0;
  endtask

  task automatic check_run(input string tag, input int limit, input int poke_c, input int abort_c);
    int   c;
    exp_t e;
    exp_t o;
    logic [9:0] hold;
    c = 0;
    done_c = -1;
    while (sb.size() > 0 && c < limit) begin
      @(negedge clk);
      c++;
      e = sb.pop_front();
      o = {o_event, o_label, o_busy, o_done, o_rep_cnt};
      if (o_done === 1'b1) done_c = c;
      n_assert++;
      assert (o === e) else begin
        n_fail++;
        $error("FAIL %s cyc %0d observed ev=%h lb=%h busy=%b done=%b rep=%0d expected ev=%h lb=%h busy=%b done=%b rep=%0d",
               tag, c, o.ev, o.lb, o.busy, o.done, o.rep, e.ev, e.lb, e.busy, e.done, e.rep);
      end
      if (c == poke_c) begin
        i_start = 1'b1; i_spl = 16'd5; i_mode = 2'd1; i_reps = 10'd7;
      end else if (poke_c > 0 && c == poke_c + 1) begin
        i_start = 1'b0;
      end
      if (c == abort_c) begin
        i_abort = 1'b1;
        hold = e.rep;
        sb.delete();
        for (int k = 0; k < 4; k++) push(8'h00, 4'h0, 1'b0, 1'b0, hold);
        @(posedge clk);
        #1 i_abort = 1'b0;
      end
    end
  endtask

  task automatic check_drained(input string tag);
    n_assert++;
    assert (sb.size() === 0) else begin
      n_fail++;
      $error("FAIL %s_timeout observed %0d pending expected 0 pending", tag, sb.size());
    end
  endtask

  task automatic check_done_cycle(input string tag, input int want);
    n_assert++;
    assert (done_c === want) else begin
      n_fail++;
      $error("FAIL %s_done_cycle observed %0d expected %0d", tag, done_c, want);
    end
  endtask

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_mode = 2'd0;
    i_spl = '0; i_dlt = '0; i_gap = '0; i_wait = '0; i_label = '0; i_reps = '0;

    // outputs held at zero in and after reset
    for (int k = 0; k < 2; k++) push(8'h00, 4'h0, 1'b0, 1'b0, 10'd0);
    check_run("in_reset", 2, 0, 0);
    i_rst_n = 1'b1;
    for (int k = 0; k < 2; k++) push(8'h00, 4'h0, 1'b0, 1'b0, 10'd0);
    check_run("idle", 2, 0, 0);

    start_run(0, 2, 14, 4, 10, 4'b0001, 1);
    check_run("mode0", 400, 0, 0);
    check_drained("mode0");
    check_done_cycle("mode0", 245);

    start_run(2, 2, 14, 4, 10, 4'b0001, 1);
    check_run("mode2", 400, 0, 0);
    check_drained("mode2");
    check_done_cycle("mode2", 245);

    // spl=0 acts as 1; zero dlt/gap/wait skip their states
    start_run(1, 0, 0, 0, 0, 4'hA, 2);
    check_run("mode1_zero", 400, 0, 0);
    check_drained("mode1_zero");
    check_done_cycle("mode1_zero", 35);

    // start pulse and config changes mid-run must be ignored
    start_run(3, 3, 1, 2, 1, 4'h5, 2);
    check_run("mode3_poke", 2000, 10, 0);
    check_drained("mode3_poke");

    start_run(0, 2, 14, 4, 10, 4'b0001, 0);
    check_run("reps0", 20, 0, 0);
    check_drained("reps0");
    check_done_cycle("reps0", 1);

    start_run(0, 2, 14, 4, 10, 4'b0001, 3);
    check_run("abort", 400, 0, 50);
    check_drained("abort");

    // start together with abort in IDLE starts nothing
    i_start = 1'b1; i_abort = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0; i_abort = 1'b0;
    for (int k = 0; k < 3; k++) push(8'h00, 4'h0, 1'b0, 1'b0, 10'd0);
    check_run("start_abort", 3, 0, 0);

    start_run(0, 1, 0, 0, 0, 4'h3, 1);
    check_run("after_abort", 400, 0, 0);
    check_drained("after_abort");

    // async reset during the second pulse
    start_run(0, 2, 14, 4, 10, 4'b0001, 1);
    check_run("pre_reset", 17, 0, 0);
    #2 i_rst_n = 1'b0;
    #1;
    n_assert++;
    assert ({o_event, o_label, o_busy, o_done, o_rep_cnt} === 24'h0) else begin
      n_fail++;
      $error("FAIL async_reset observed ev=%h lb=%h busy=%b expected all zero", o_event, o_label, o_busy);
    end
    sb.delete();
    @(negedge clk);
    i_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) push(8'h00, 4'h0, 1'b0, 1'b0, 10'd0);
    check_run("post_reset", 3, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
